fx68_bus_ctrl: RTL and testbench

- Parametrised 68000 bus controller between the fx68k core and on-chip slaves (ROM/BRAM, VRAM, RAM, SDRAM port, I/O).
- Generates the Phi1/Phi2 clock enables and decodes the address into N one-hot regions.
- Inserts per-region wait states, or waits for a slave ready, then drives DTACKn; drives BERRn on timeout or unmapped access.
- Multiplexes and registers slave read data onto the CPU input bus, so a fixed tied-low DTACKn is no longer needed.

---
 rtl/fx68_bus_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_fx68_bus_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fx68_bus_ctrl.sv
// fx68k bus controller: Phi1/Phi2 enables, region decode, wait-state/ready
// handling, DTACKn/BERRn generation and registered read-data return.
module fx68_bus_ctrl #(
  parameter int                  C_SLOWDOWN      = 2,
  parameter int                  C_REGIONS       = 4,
  parameter int                  C_SEL_HI        = 17,
  parameter int                  C_SEL_LO        = 15,
  parameter int                  C_WAIT_BITS     = 4,
  parameter logic [C_REGIONS-1:0] C_EXT_MASK     = '0,
  parameter int                  C_TIMEOUT       = 255,
  parameter bit                  C_BERR_UNMAPPED = 1'b1
) (
  input  logic                             clk,
  input  logic                             reset,
  output logic                             phi1,
  output logic                             phi2,
  input  logic                             cpu_as_n,
  input  logic                             cpu_rw,
  input  logic                             cpu_uds_n,
  input  logic                             cpu_lds_n,
  input  logic [22:0]                      cpu_a,
  input  logic [C_REGIONS*C_WAIT_BITS-1:0] wait_cfg,
  input  logic [C_REGIONS-1:0]             ext_ready,
  input  logic [C_REGIONS*16-1:0]          slave_dout,
  output logic [C_REGIONS-1:0]             sel,
  output logic                             rd_stb,
  output logic                             wr_stb,
  output logic [1:0]                       be,
  output logic [15:0]                      cpu_din,
  output logic                             dtack_n,
  output logic                             berr_n,
  output logic                             busy
);

  localparam int SELW = C_SEL_HI - C_SEL_LO + 1;
  localparam int RIW  = (C_REGIONS > 1) ? $clog2(C_REGIONS) : 1;
  localparam int NPAD = 1 << RIW;
  localparam int TW   = $clog2(C_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(C_TIMEOUT);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;
  localparam logic [1:0] S_BERR = 2'd3;

  logic                   r_phi1, r_phi2;
  logic [1:0]             r_state;
  logic [RIW-1:0]         r_idx;
  logic                   r_rw;
  logic                   r_armed;
  logic [1:0]             r_be;
  logic [C_REGIONS-1:0]   r_sel;
  logic                   r_rd_stb, r_wr_stb;
  logic [C_WAIT_BITS-1:0] r_wcnt;
  logic [TW-1:0]          r_tmo;
  logic [15:0]            r_din;
  logic                   r_dtack_n, r_berr_n;

  logic [SELW-1:0]        w_sel_fld;
  logic [RIW-1:0]         w_ridx;
  logic                   w_mapped;
  logic [TW-1:0]          w_tmo_nxt;
  logic                   w_tmo_hit;
  logic [C_WAIT_BITS-1:0] w_wcfg  [NPAD];
  logic [15:0]            w_sdout [NPAD];
  logic [NPAD-1:0]        w_rdy;
  logic                   w_unused_a;

  // Phi enables: divided counter, or a plain toggle when running full speed.
  if (C_SLOWDOWN > 0) begin : g_phi_div
    localparam int HALF = 1 << (C_SLOWDOWN - 1);
    logic [C_SLOWDOWN-1:0] r_pcnt;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_pcnt <= '0;
        r_phi1 <= 1'b0;
        r_phi2 <= 1'b0;
      end else begin
        r_pcnt <= r_pcnt + C_SLOWDOWN'(1);
        r_phi1 <= (r_pcnt == '0);
        r_phi2 <= (r_pcnt == C_SLOWDOWN'(HALF));
      end
    end
  end else begin : g_phi_tog
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_phi1 <= 1'b0;
        r_phi2 <= 1'b0;
      end else begin
        r_phi1 <= ~r_phi1;
        r_phi2 <= r_phi1;
      end
    end
  end

  // Per-region views padded to a power of two so the index never runs off the end.
  for (genvar g = 0; g < NPAD; g++) begin : g_reg
    if (g < C_REGIONS) begin : g_map
      assign w_wcfg[g]  = wait_cfg[g*C_WAIT_BITS +: C_WAIT_BITS];
      assign w_sdout[g] = slave_dout[g*16 +: 16];
      assign w_rdy[g]   = ~C_EXT_MASK[g] | ext_ready[g];
    end else begin : g_pad
      assign w_wcfg[g]  = '0;
      assign w_sdout[g] = '0;
      assign w_rdy[g]   = 1'b0;
    end
  end

  assign w_sel_fld  = cpu_a[C_SEL_HI:C_SEL_LO];
  assign w_ridx     = w_sel_fld[RIW-1:0];
  assign w_mapped   = (int'(w_sel_fld) < C_REGIONS);
  assign w_unused_a = ^cpu_a;

  assign w_tmo_nxt = (r_phi1 && (r_tmo != TMO_MAX)) ? r_tmo + TW'(1) : r_tmo;
  assign w_tmo_hit = (w_tmo_nxt == TMO_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_rw      <= 1'b1;
      r_armed   <= 1'b1;
      r_be      <= '0;
      r_sel     <= '0;
      r_rd_stb  <= 1'b0;
      r_wr_stb  <= 1'b0;
      r_wcnt    <= '0;
      r_tmo     <= '0;
      r_din     <= '0;
      r_dtack_n <= 1'b1;
      r_berr_n  <= 1'b1;
    end else begin
      r_rd_stb <= 1'b0;
      r_wr_stb <= 1'b0;
      // A new cycle is only taken once AS has been seen released.
      if (cpu_as_n) r_armed <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (!cpu_as_n && r_armed) begin
            r_armed <= 1'b0;
            if (w_mapped) begin
              r_idx    <= w_ridx;
              r_rw     <= cpu_rw;
              r_be     <= {~cpu_uds_n, ~cpu_lds_n};
              r_sel    <= C_REGIONS'(1) << w_ridx;
              r_rd_stb <= cpu_rw;
              r_wr_stb <= ~cpu_rw;
              r_wcnt   <= w_wcfg[w_ridx];
              r_tmo    <= '0;
              r_state  <= S_WAIT;
            end else if (C_BERR_UNMAPPED) begin
              r_berr_n <= 1'b0;
              r_state  <= S_BERR;
            end else begin
              r_din     <= 16'hFFFF;
              r_dtack_n <= 1'b0;
              r_state   <= S_ACK;
            end
          end
        end
        S_WAIT: begin
          if (cpu_as_n) begin
            r_sel   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_tmo <= w_tmo_nxt;
            if (r_phi1 && (r_wcnt != '0)) r_wcnt <= r_wcnt - C_WAIT_BITS'(1);
            // Timeout beats a ready arriving on the same edge.
            if (w_tmo_hit) begin
              r_berr_n <= 1'b0;
              r_state  <= S_BERR;
            end else if ((r_wcnt == '0) && w_rdy[r_idx]) begin
              if (r_rw) r_din <= w_sdout[r_idx];
              r_dtack_n <= 1'b0;
              r_state   <= S_ACK;
            end
          end
        end
        S_ACK: begin
          if (cpu_as_n) begin
            r_dtack_n <= 1'b1;
            r_sel     <= '0;
            r_state   <= S_IDLE;
          end
        end
        S_BERR: begin
          if (cpu_as_n) begin
            r_berr_n <= 1'b1;
            r_sel    <= '0;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign phi1    = r_phi1;
  assign phi2    = r_phi2;
  assign sel     = r_sel;
  assign rd_stb  = r_rd_stb;
  assign wr_stb  = r_wr_stb;
  assign be      = r_be;
  assign cpu_din = r_din;
  assign dtack_n = r_dtack_n;
  assign berr_n  = r_berr_n;
  assign busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_fx68_bus_ctrl.sv
// Bench for fx68_bus_ctrl: instance A (slow phi, ext region 2, short timeout,
// BERR on unmapped) and instance B (full-speed phi, unmapped reads 16'hFFFF).
module tb_fx68_bus_ctrl;
  logic        clk = 1'b0, reset = 1'b1;
  logic        as_n = 1'b1, rw = 1'b1, uds_n = 1'b1, lds_n = 1'b1;
  logic [22:0] a = '0;
  logic [15:0] wcfg = '0;
  logic [3:0]  erdy = '0;
  logic [63:0] sdout = '0;

  logic        a_phi1, a_phi2, a_rd, a_wr, a_dtack_n, a_berr_n, a_busy;
  logic [3:0]  a_sel;
  logic [1:0]  a_be;
  logic [15:0] a_din;
  logic        b_phi1, b_phi2, b_rd, b_wr, b_dtack_n, b_berr_n, b_busy;
  logic [3:0]  b_sel;
  logic [1:0]  b_be;
  logic [15:0] b_din;

  int          checks = 0, failures = 0;
  int          cyc;
  logic [15:0] m_din_a = '0;

  fx68_bus_ctrl #(.C_SLOWDOWN(2), .C_REGIONS(4), .C_EXT_MASK(4'b0100),
                  .C_TIMEOUT(8), .C_BERR_UNMAPPED(1'b1)) u_a (
    .clk(clk), .reset(reset), .phi1(a_phi1), .phi2(a_phi2),
    .cpu_as_n(as_n), .cpu_rw(rw), .cpu_uds_n(uds_n), .cpu_lds_n(lds_n), .cpu_a(a),
    .wait_cfg(wcfg), .ext_ready(erdy), .slave_dout(sdout),
    .sel(a_sel), .rd_stb(a_rd), .wr_stb(a_wr), .be(a_be), .cpu_din(a_din),
    .dtack_n(a_dtack_n), .berr_n(a_berr_n), .busy(a_busy));

  fx68_bus_ctrl #(.C_SLOWDOWN(0), .C_REGIONS(4), .C_BERR_UNMAPPED(1'b0)) u_b (
    .clk(clk), .reset(reset), .phi1(b_phi1), .phi2(b_phi2),
    .cpu_as_n(as_n), .cpu_rw(rw), .cpu_uds_n(uds_n), .cpu_lds_n(lds_n), .cpu_a(a),
    .wait_cfg(wcfg), .ext_ready(erdy), .slave_dout(sdout),
    .sel(b_sel), .rd_stb(b_rd), .wr_stb(b_wr), .be(b_be), .cpu_din(b_din),
    .dtack_n(b_dtack_n), .berr_n(b_berr_n), .busy(b_busy));

  always #5 clk = ~clk;

  // Edges counted since reset release give the expected phi phase.
  always @(posedge clk or posedge reset)
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;

  localparam logic [28:0] RST_VEC = {2'b00, 4'b0000, 1'b0, 1'b0, 2'b00, 16'h0000, 1'b1, 1'b1, 1'b0};

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_phi1, a_phi2, a_sel, a_rd, a_wr, a_be, a_din, a_dtack_n, a_berr_n, a_busy} !== RST_VEC) begin
      failures++;
      $display("FAIL reset_a: got %h want %h", {a_phi1, a_phi2, a_sel, a_rd, a_wr, a_be, a_din, a_dtack_n, a_berr_n, a_busy}, RST_VEC);
    end
    checks++;
    if ({b_phi1, b_phi2, b_sel, b_rd, b_wr, b_be, b_din, b_dtack_n, b_berr_n, b_busy} !== RST_VEC) begin
      failures++;
      $display("FAIL reset_b: got %h want %h", {b_phi1, b_phi2, b_sel, b_rd, b_wr, b_be, b_din, b_dtack_n, b_berr_n, b_busy}, RST_VEC);
    end
    @(negedge clk);
    reset = 1'b0;
    m_din_a = '0;
  endtask

  task automatic test_phi();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if ({a_phi1, a_phi2} !== {cyc % 4 == 1, cyc % 4 == 3}) begin
        failures++;
        $display("FAIL phi_a cyc=%0d: got %b%b want %b%b", cyc, a_phi1, a_phi2, cyc % 4 == 1, cyc % 4 == 3);
      end
      checks++;
      if ({b_phi1, b_phi2} !== {cyc % 2 == 1, cyc % 2 == 0}) begin
        failures++;
        $display("FAIL phi_b cyc=%0d: got %b%b want %b%b", cyc, b_phi1, b_phi2, cyc % 2 == 1, cyc % 2 == 0);
      end
    end
  endtask

  task automatic test_read_basic();
    wcfg[3:0] = 4'd0; sdout[15:0] = 16'h1234;
    a = 23'h000080; rw = 1'b1; uds_n = 1'b0; lds_n = 1'b0; as_n = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if ({a_sel, a_rd, a_dtack_n, b_sel, b_rd} !== {4'b0001, 1'b1, 1'b1, 4'b0001, 1'b1}) begin
      failures++;
      $display("FAIL rd0_sel: got %b %b %b %b %b", a_sel, a_rd, a_dtack_n, b_sel, b_rd);
    end
    @(negedge clk);
    checks++;
    if ({a_dtack_n, a_din, a_rd, b_dtack_n, b_din} !== {1'b0, 16'h1234, 1'b0, 1'b0, 16'h1234}) begin
      failures++;
      $display("FAIL rd0_ack: got %b %h %b %b %h want 0 1234 0 0 1234", a_dtack_n, a_din, a_rd, b_dtack_n, b_din);
    end
    m_din_a = 16'h1234;
    as_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_dtack_n, a_sel, a_busy, b_dtack_n, b_sel} !== {1'b1, 4'b0, 1'b0, 1'b1, 4'b0}) begin
      failures++;
      $display("FAIL rd0_end: got %b %b %b %b %b", a_dtack_n, a_sel, a_busy, b_dtack_n, b_sel);
    end
  endtask

  // One CPU cycle on instance A. rdy_dly<0: ext_ready never rises.
  task automatic txn(input int ri, input logic rwv, input logic udsv, input logic ldsv, input int rdy_dly);
    int rem, tmo, ex;
    logic pprev, done, rdy;
    logic [3:0] oh;
    logic [9:0] want;
    a = 23'($urandom); a[17:15] = 3'(ri);
    rw = rwv; uds_n = udsv; lds_n = ldsv; erdy = '0; as_n = 1'b0;
    @(posedge clk); @(negedge clk);
    if (ri >= 4) begin
      checks++;
      if ({a_berr_n, a_dtack_n, a_sel, a_busy} !== {1'b0, 1'b1, 4'b0, 1'b1}) begin
        failures++;
        $display("FAIL unmapped_berr r=%0d: got %b %b %b %b want 0 1 0000 1", ri, a_berr_n, a_dtack_n, a_sel, a_busy);
      end
    end else begin
      oh = '0; oh[ri] = 1'b1;
      want = {oh, rwv, ~rwv, ~udsv, ~ldsv, 1'b1, 1'b1};
      checks++;
      if ({a_sel, a_rd, a_wr, a_be, a_dtack_n, a_busy} !== want) begin
        failures++;
        $display("FAIL start r=%0d: got %b want %b", ri, {a_sel, a_rd, a_wr, a_be, a_dtack_n, a_busy}, want);
      end
      uds_n = 1'($urandom); lds_n = 1'($urandom);
      rem = int'(wcfg[ri*4 +: 4]); tmo = 0; pprev = (cyc % 4 == 1); done = 1'b0;
      for (int t = 0; t < 200 && !done; t++) begin
        if (t == rdy_dly) erdy = '1;
        rdy = (ri != 2) || erdy[2];
        @(posedge clk);
        ex = 0;
        if (pprev) tmo++;
        if (tmo == 8) ex = 2;
        else if (rem == 0 && rdy) ex = 1;
        else if (pprev && rem > 0) rem--;
        @(negedge clk);
        pprev = (cyc % 4 == 1);
        checks++;
        if (ex == 1) begin
          if (rwv) m_din_a = sdout[ri*16 +: 16];
          done = 1'b1;
          if ({a_dtack_n, a_berr_n, a_din, a_be} !== {1'b0, 1'b1, m_din_a, ~udsv, ~ldsv}) begin
            failures++;
            $display("FAIL ack r=%0d t=%0d: got %b %b %h %b want 0 1 %h %b", ri, t, a_dtack_n, a_berr_n, a_din, a_be, m_din_a, {~udsv, ~ldsv});
          end
        end else if (ex == 2) begin
          done = 1'b1;
          if ({a_dtack_n, a_berr_n} !== 2'b10) begin
            failures++;
            $display("FAIL timeout r=%0d t=%0d: got %b%b want 10", ri, t, a_dtack_n, a_berr_n);
          end
          erdy = '1;
        end else if ({a_dtack_n, a_berr_n, a_busy} !== 3'b111) begin
          failures++;
          $display("FAIL stall r=%0d t=%0d: got %b want 111", ri, t, {a_dtack_n, a_berr_n, a_busy});
        end
      end
      checks++;
      if (!done) begin
        failures++;
        $display("FAIL no_response r=%0d: got none want dtack or berr", ri);
      end
      @(negedge clk);
      checks++;
      if ({a_dtack_n, a_berr_n, a_din} !== {(ex == 1) ? 2'b01 : 2'b10, m_din_a}) begin
        failures++;
        $display("FAIL hold r=%0d: got %b%b %h want %b %h", ri, a_dtack_n, a_berr_n, a_din, (ex == 1) ? 2'b01 : 2'b10, m_din_a);
      end
    end
    as_n = 1'b1;
    @(negedge clk);
    erdy = '0;
    checks++;
    if ({a_dtack_n, a_berr_n, a_sel, a_busy} !== {1'b1, 1'b1, 4'b0, 1'b0}) begin
      failures++;
      $display("FAIL release r=%0d: got %b %b %b %b want 1 1 0000 0", ri, a_dtack_n, a_berr_n, a_sel, a_busy);
    end
  endtask

  task automatic test_write_wait();
    wcfg[15:12] = 4'd3;
    txn(3, 1'b0, 1'b0, 1'b1, 0);
  endtask

  task automatic test_ext_timeout();
    wcfg[11:8] = 4'd1;
    sdout[47:32] = 16'($urandom);
    txn(2, 1'b1, 1'b0, 1'b0, -1);
    txn(2, 1'b1, 1'b0, 1'b0, 6);
  endtask

  task automatic test_unmapped();
    a = '0; a[17:15] = 3'd5; rw = 1'b1; uds_n = 1'b0; lds_n = 1'b0; as_n = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if ({a_berr_n, a_dtack_n, a_sel} !== {1'b0, 1'b1, 4'b0}) begin
      failures++;
      $display("FAIL unmapped_a: got %b %b %b want 0 1 0000", a_berr_n, a_dtack_n, a_sel);
    end
    checks++;
    if ({b_dtack_n, b_berr_n, b_din, b_sel} !== {1'b0, 1'b1, 16'hFFFF, 4'b0}) begin
      failures++;
      $display("FAIL unmapped_b: got %b %b %h %b want 0 1 ffff 0000", b_dtack_n, b_berr_n, b_din, b_sel);
    end
    as_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_berr_n, a_busy, b_dtack_n, b_busy} !== 4'b1010) begin
      failures++;
      $display("FAIL unmapped_end: got %b want 1010", {a_berr_n, a_busy, b_dtack_n, b_busy});
    end
  endtask

  task automatic test_abort_reset();
    wcfg[7:4] = 4'd15;
    a = '0; a[17:15] = 3'd1; rw = 1'b1; as_n = 1'b0;
    @(posedge clk); @(negedge clk);
    repeat (2) @(negedge clk);
    as_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_dtack_n, a_berr_n, a_sel, a_busy} !== {1'b1, 1'b1, 4'b0, 1'b0}) begin
      failures++;
      $display("FAIL abort: got %b %b %b %b want 1 1 0000 0", a_dtack_n, a_berr_n, a_sel, a_busy);
    end
    as_n = 1'b0;
    @(posedge clk); @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({a_phi1, a_phi2, a_sel, a_rd, a_wr, a_be, a_din, a_dtack_n, a_berr_n, a_busy} !== RST_VEC) begin
      failures++;
      $display("FAIL async_reset: got %h want %h", {a_phi1, a_phi2, a_sel, a_rd, a_wr, a_be, a_din, a_dtack_n, a_berr_n, a_busy}, RST_VEC);
    end
    wcfg[7:4] = 4'd0;
    sdout[31:16] = 16'($urandom);
    @(negedge clk);
    reset = 1'b0;
    m_din_a = '0;
    @(posedge clk); @(negedge clk);
    checks++;
    if ({a_sel, a_rd, a_dtack_n} !== {4'b0010, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL post_reset_start: got %b %b %b want 0010 1 1", a_sel, a_rd, a_dtack_n);
    end
    @(negedge clk);
    checks++;
    if ({a_dtack_n, a_din} !== {1'b0, sdout[31:16]}) begin
      failures++;
      $display("FAIL post_reset_ack: got %b %h want 0 %h", a_dtack_n, a_din, sdout[31:16]);
    end
    m_din_a = sdout[31:16];
    as_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int ri, st, dly;
    logic rwv;
    for (int n = 0; n < 24; n++) begin
      wcfg  = 16'($urandom);
      sdout = {$urandom, $urandom};
      ri    = int'($urandom_range(0, 7));
      rwv   = 1'($urandom);
      st    = int'($urandom_range(0, 2));
      dly   = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 20));
      txn(ri, rwv, st == 2, st == 1, dly);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_phi();
    test_read_basic();
    test_write_wait();
    test_ext_timeout();
    test_unmapped();
    test_abort_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
